// File: rtl/fix2flt_pkg.sv
// Shared float32 definitions for the SZ float-side blocks.
// Holds field widths, exponent bias and the packed float32 layout.
package fix2flt_pkg;

    localparam int FLT_EXP_W = 8;
    localparam int FLT_MAN_W = 23;
    localparam int FLT_BIAS  = 127;

    typedef struct packed {
        logic                 sign;
        logic [FLT_EXP_W-1:0] exp;
        logic [FLT_MAN_W-1:0] man;
    } flt32_t;

endpackage

// File: rtl/fix2flt_pipe_lzc_tree.sv
// Combinational leading-zero counter; an all-zero word counts as W.
// The highest set bit wins because later loop iterations override.
module lzc_tree #(
    parameter int W = 32,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fix2flt_pipe.sv
// Four-stage fixed-point to float32 converter with valid/ready on both sides.
// Stages: sign/magnitude, leading-zero count, normalise, round-and-pack.
module fix2flt_pipe
    import fix2flt_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 0,
    parameter int SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [IN_W-1:0] s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [31:0]     m_data
);

    localparam int LZ_W  = $clog2(IN_W + 1);
    localparam int EXT_W = (IN_W > 26) ? IN_W : 26;
    localparam int EBASE = FLT_BIAS + IN_W - 1 - FRAC_W;

    generate
        if (IN_W < 2 || IN_W > 64 || FRAC_W < 0 || FRAC_W > 64 ||
            FLT_BIAS + IN_W - FRAC_W > 254 ||
            IN_W - 1 - FRAC_W < -126) begin : g_bad_params
            $error("fix2flt_pipe: illegal IN_W/FRAC_W combination");
        end
    endgenerate

    logic v1, v2, v3, v4;
    logic en1, en2, en3, en4;

    // A stage may load when empty or when its occupant moves on.
    assign en4 = !v4 || m_ready;
    assign en3 = !v3 || en4;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;

    assign s_ready = en1;
    assign m_valid = v4;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            if (en1) v1 <= s_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
            if (en4) v4 <= v3;
        end
    end

    logic            sign_in;
    logic [IN_W-1:0] mag_in;

    assign sign_in = (SIGNED != 0) && s_data[IN_W-1];
    assign mag_in  = sign_in ? -s_data : s_data;

    logic            sign1, zero1;
    logic [IN_W-1:0] mag1;
    logic            sign2, zero2;
    logic [IN_W-1:0] mag2;
    logic [LZ_W-1:0] lz2;
    logic            sign3, zero3;
    logic [IN_W-1:0] norm3;
    logic [8:0]      exp3;
    logic [LZ_W-1:0] lz_c;

    lzc_tree #(.W(IN_W)) u_lzc (
        .din (mag1),
        .cnt (lz_c)
    );

    always_ff @(posedge clk) begin
        if (en1) begin
            sign1 <= sign_in;
            mag1  <= mag_in;
            zero1 <= (mag_in == '0);
        end
        if (en2) begin
            sign2 <= sign1;
            mag2  <= mag1;
            zero2 <= zero1;
            lz2   <= lz_c;
        end
        if (en3) begin
            sign3 <= sign2;
            zero3 <= zero2;
            norm3 <= mag2 << lz2;
            exp3  <= 9'(EBASE) - 9'(lz2);
        end
    end

    // Pad narrow words so guard and sticky always have a home.
    logic [EXT_W-1:0] ext;
    logic [23:0]      sig;
    logic             guard, sticky, inc;
    logic [24:0]      sum;
    flt32_t           res, out4;

    always_comb begin
        ext    = EXT_W'(norm3) << (EXT_W - IN_W);
        sig    = ext[EXT_W-1 -: 24];
        guard  = ext[EXT_W-25];
        sticky = |ext[EXT_W-26:0];
        inc    = guard && (sticky || sig[0]);
        sum    = {1'b0, sig} + 25'(inc);
        res      = '0;
        res.sign = sign3;
        res.exp  = sum[24] ? exp3[7:0] + 8'd1 : exp3[7:0];
        res.man  = sum[22:0];
        if (zero3) res = '0;
    end

    logic unused_bits;
    assign unused_bits = ^{sum[23], exp3[8]};

    always_ff @(posedge clk) begin
        if (rst) out4 <= '0;
        else if (en4) out4 <= res;
    end

    assign m_data = out4;

endmodule

// File: tb/tb_fix2flt_pipe.sv
// Self-checking bench: scoreboard against an integer-arithmetic float model.
// Three instances cover signed/fraction/unsigned parameter sets.
module tb_fix2flt_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_sv, a_sr, a_mv, a_mr;
    logic [31:0] a_sd, a_md;
    logic        b_sv, b_sr, b_mv, b_mr;
    logic [31:0] b_sd, b_md;
    logic        c_sv, c_sr, c_mv, c_mr;
    logic [31:0] c_sd, c_md;

    fix2flt_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(1)) dut_a (
        .clk(clk), .rst(rst), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md)
    );
    fix2flt_pipe #(.IN_W(32), .FRAC_W(16), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md)
    );
    fix2flt_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .s_valid(c_sv), .s_ready(c_sr), .s_data(c_sd),
        .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Float value of d * 2^-fw, rounded to nearest even on integer arithmetic.
    function automatic logic [31:0] model(input logic [63:0] d, input int inw,
                                          input int fw, input bit sg);
        longint unsigned mask, m, q, rem, half;
        bit s;
        int p, e, sh;
        mask = (inw == 64) ? '1 : ((64'd1 << inw) - 1);
        m = d & mask;
        s = sg && d[inw-1];
        if (s) m = ((~m) + 1) & mask;
        if (m == 0) return 32'h0;
        p = 63;
        while (!m[p]) p--;
        e = 127 + p - fw;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh = p - 23;
            q = m >> sh;
            rem = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {s, 8'(e), q[22:0]};
    endfunction

    typedef struct {
        logic [31:0] mdl;
        logic [31:0] lit;
        bit          has_lit;
        int          t;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    bit          lat_on = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] cur_lit = '0;
    bit          cur_has = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", a_mv, 1);
                chk("hold_data", a_md, prev_data);
            end
            if (a_mv && a_mr) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("model", a_md, e.mdl);
                    if (e.has_lit) chk("literal", a_md, e.lit);
                    if (lat_on) chk("latency", cyc - e.t, 4);
                end
            end
            if (a_sv && a_sr)
                sb.push_back('{model(a_sd, 32, 0, 1), cur_lit, cur_has, cyc});
            prev_stall = a_mv && !a_mr;
            prev_data  = a_md;
        end
    end

    task automatic send(input logic [31:0] d, input logic [31:0] lit, input bit has);
        int w;
        bit acc;
        a_sv = 1'b1;
        a_sd = d;
        cur_lit = lit;
        cur_has = has;
        w = 0;
        acc = 1'b0;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = a_sr;
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        a_sv = 1'b0;
        cur_has = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (sb.size() != 0 || a_mv); n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic run_bc(input logic [31:0] db, input logic [31:0] eb,
                          input logic [31:0] dc, input logic [31:0] ec);
        bit gb, gc;
        b_sv = 1'b1; b_sd = db;
        c_sv = 1'b1; c_sd = dc;
        @(negedge clk);
        chk("bc_ready", {b_sr, c_sr}, 2'b11);
        @(posedge clk);
        #1;
        b_sv = 1'b0;
        c_sv = 1'b0;
        gb = 1'b0;
        gc = 1'b0;
        for (int n = 1; n <= 12 && !(gb && gc); n++) begin
            @(negedge clk);
            if (b_mv && !gb) begin
                gb = 1'b1;
                chk("b_literal", b_md, eb);
                chk("b_model", b_md, model(db, 32, 16, 1));
                chk("b_latency", n, 4);
            end
            if (c_mv && !gc) begin
                gc = 1'b1;
                chk("c_literal", c_md, ec);
                chk("c_model", c_md, model(dc, 32, 0, 0));
                chk("c_latency", n, 4);
            end
            @(posedge clk);
            #1;
        end
        if (!gb) chk("b_timeout", 0, 1);
        if (!gc) chk("c_timeout", 0, 1);
    endtask

    logic [31:0] vec_d [10] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                                32'h7FFFFFFF, 32'h80000000, 32'd16777217,
                                32'd16777219, 32'd16777221, 32'h00000064,
                                32'hFFFFFFFE};
    logic [31:0] vec_e [10] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                                32'h4F000000, 32'hCF000000, 32'h4B800000,
                                32'h4B800002, 32'h4B800002, 32'h42C80000,
                                32'hC0000000};
    logic [31:0] bp [8] = '{32'h00000010, 32'hFFFFFF00, 32'h12345678,
                            32'h00FFFFFF, 32'h01000001, 32'h80000001,
                            32'h00000007, 32'h7FFFFFC0};

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bit sr_fell;
        a_sv = 0; a_sd = '0; a_mr = 1'b1;
        b_sv = 0; b_sd = '0; b_mr = 1'b1;
        c_sv = 0; c_sd = '0; c_mr = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", a_mv, 0);
        chk("reset_s_ready", a_sr, 1);
        chk("reset_m_data", a_md, 0);

        chk("pin_max", model(32'h7FFFFFFF, 32, 0, 1), 32'h4F000000);
        chk("pin_tie_up", model(32'd16777219, 32, 0, 1), 32'h4B800002);
        chk("pin_frac", model(32'h00018000, 32, 16, 1), 32'h3FC00000);
        chk("pin_unsigned", model(32'hFFFFFFFF, 32, 0, 0), 32'h4F800000);
        @(posedge clk);
        #1;

        lat_on = 1'b1;
        for (int i = 0; i < 10; i++) send(vec_d[i], vec_e[i], 1'b1);
        for (int i = 0; i < 8; i++) send($urandom, 32'h0, 1'b0);
        drain();

        lat_on = 1'b0;
        idx = 0;
        sr_fell = 1'b0;
        for (int k = 0; k < 60 && idx < 8; k++) begin
            a_mr = !(k >= 2 && k <= 11);
            a_sv = 1'b1;
            a_sd = bp[idx];
            @(negedge clk);
            if (a_sr) idx++;
            else if (!sr_fell) begin
                sr_fell = 1'b1;
                chk("s_ready_fall_count", idx, 4);
            end
            @(posedge clk);
            #1;
        end
        a_sv = 1'b0;
        a_mr = 1'b1;
        chk("s_ready_fell", sr_fell, 1);
        chk("bp_all_sent", idx, 8);
        drain();

        lat_on = 1'b1;
        send(32'h00000005, 32'h40A00000, 1'b1);
        send(32'h00000006, 32'h40C00000, 1'b1);
        send(32'h00000007, 32'h40E00000, 1'b1);
        rst = 1'b1;
        a_sv = 1'b1;
        a_sd = 32'h00001234;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_sv = 1'b0;
        @(negedge clk);
        chk("post_rst_m_valid", a_mv, 0);
        chk("post_rst_s_ready", a_sr, 1);
        @(posedge clk);
        #1;
        send(32'h00000002, 32'h40000000, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        drain();

        run_bc(32'h00018000, 32'h3FC00000, 32'hFFFFFFFF, 32'h4F800000);
        run_bc(32'hFFFF0000, 32'hBF800000, 32'h00000001, 32'h3F800000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fix2flt_pipe.md
# fix2flt_pipe

Parametrised, natively pipelined fixed-point to IEEE-754 single-precision converter for the SZ front-end stages. It accepts signed or unsigned fixed-point words of configurable width and fraction position, and returns rounded float32 results. A valid/ready stream handshake on both sides provides full backpressure. It replaces the vendor-IP converter with an always-asserted handshake, so quantised prediction values can be turned back into floats inside stallable pipelines.

## Interface
- IN_W, 32, input word width; legal range 2..64
- FRAC_W, 0, number of fraction bits in the input; legal range 0..64; value = s_data * 2^-FRAC_W
- SIGNED, 1, 1 = two's-complement input, 0 = unsigned input
- clk  input  1  single clock; all logic is rising-edge
- rst  input  1  reset, synchronous and active-high
- s_valid  input  1  input word valid
- s_ready  output  1  block can accept the word this cycle
- s_data  input  IN_W  fixed-point input
- m_valid  output  1  result valid
- m_ready  input  1  downstream accepts the result
- m_data  output  32  float32 result: {sign, exp[7:0], man[22:0]}

## Operation
- Transfer happens on a cycle where valid && ready; this is identical on both sides.
- S1 (sign/magnitude):
  - sign = SIGNED && s_data[IN_W-1].
  - mag = |s_data|, held IN_W bits wide, so the most negative value gives mag = 2^(IN_W-1) without overflow.
  - zero flag = (mag == 0).
- S2 (count): lz = leading-zero count of mag, computed by lzc_tree.
- S3 (normalise):
  - norm = mag << lz, so the MSB is 1.
  - exp = 127 + (IN_W-1-lz) - FRAC_W, 9-bit signed intermediate.
- S4 (round/pack):
  - Take the top 24 bits of norm as the significand.
  - guard = next bit; sticky = OR of all remaining bits.
  - Round to nearest, ties to even: increment when guard && (sticky || lsb).
  - If the increment carries out of 24 bits, the significand becomes 1.0 and exp increments.
  - When IN_W ≤ 24 the result is exact and no rounding occurs.
- Zero input produces +0.0 (0x00000000), including negative-zero-free signed zero.
- The parameter ranges guarantee 1 ≤ exp ≤ 254 (worst cases: 127-64-64+1 is excluded by the assertion IN_W-1-FRAC_W ≥ -126). Denormal, Inf and NaN outputs are never produced.
- Elaboration-time assertion: IN_W in 2..64, FRAC_W in 0..64, and 127+IN_W-FRAC_W ≤ 254.

## Timing
- Latency is exactly 4 cycles from input acceptance to m_valid when m_ready is held high.
- Throughput is 1 word/cycle.
- Each stage has its own valid bit.
- A stage loads when it is empty or when its content moves forward this cycle, so bubbles collapse.
- s_ready = !v1 || stage 1 advances. This is combinational from m_ready through the valid chain; no skid buffer.
- With m_ready low, the pipeline fills, holding up to 4 words. s_ready deasserts only once all 4 stages hold data.
- m_data and m_valid stay stable while m_valid && !m_ready.
- Reset values: all stage valids are 0, so m_valid = 0 and s_ready = 1 in the cycle after rst is sampled high. m_data resets to 0.
- Reset mid-operation discards all in-flight words; none is emitted afterwards.
- A simultaneous s_valid during rst is ignored.
- Data registers do not need reset beyond m_data; only the valid bits are reset.

## Structure
- Shared package fix2flt_pkg holds:
  - FLT_EXP_W = 8, FLT_MAN_W = 23, FLT_BIAS = 127.
  - A packed float32 struct type {sign, exp, man}, reused by other SZ float-side blocks.
- Sub-module lzc_tree: parametrised-width, purely combinational leading-zero counter with output width $clog2(IN_W+1). It is instantiated in S2.
- Target implementation size is about 200 lines in total.

## Test plan
- IN_W=32, FRAC_W=0, SIGNED=1: inputs 1, -1, 0 -> 0x3F800000, 0xBF800000, 0x00000000, each after exactly 4 cycles.
- Extremes, same configuration: 0x7FFFFFFF -> 0x4F000000 (rounds up to 2^31); 0x80000000 -> 0xCF000000.
- RNE ties: 16777217 -> 0x4B800000 (tie, stays even); 16777219 -> 0x4B800002 (tie, rounds up); 16777221 -> 0x4B800002 (tie, stays even).
- FRAC_W=16: 0x00018000 -> 0x3FC00000 (1.5); 0xFFFF0000 -> 0xBF800000 (-1.0). With SIGNED=0, 0xFFFFFFFF at FRAC_W=0 -> 0x4F800000.
- Backpressure: stream 8 consecutive words with m_ready low for cycles 2..11.
  - s_ready falls after 4 accepted words.
  - No loss or duplication; output order equals input order.
  - m_data is held stable while stalled.
- Reset: assert rst for 1 cycle while 3 words are in flight. m_valid is 0 the next cycle, no stale word ever appears, and a new input afterwards emerges 4 cycles later.
